// File: rtl/vote_filter_if.sv
// Bundles the sample inputs and filtered-vote outputs of vote_filter.
interface vote_filter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N + 1)
);
    logic          en;
    logic [N-1:0]  in;
    logic [CW-1:0] thr;
    logic          vote_out;
    logic [CW-1:0] count;
    logic          rise;
    logic          fall;

    // Source side: drives samples and threshold, observes the filtered vote.
    modport master (
        output en,
        output in,
        output thr,
        input  vote_out,
        input  count,
        input  rise,
        input  fall
    );

    // Filter side.
    modport slave (
        input  en,
        input  in,
        input  thr,
        output vote_out,
        output count,
        output rise,
        output fall
    );
endinterface

// File: rtl/vote_filter.sv
// Threshold voter over N channels followed by a HOLD-sample persistence filter.
// vote_out only changes after HOLD consecutive enabled samples agree on the new value.
module vote_filter #(
    parameter int unsigned N    = 4,
    parameter int unsigned CW   = $clog2(N + 1),
    parameter int unsigned HOLD = 2,
    parameter int unsigned RW   = $clog2(HOLD + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    vote_filter_if.slave bus
);

    typedef enum logic [1:0] {
        StLo     = 2'd0,
        StPendHi = 2'd1,
        StHi     = 2'd2,
        StPendLo = 2'd3
    } state_e;

    // Value of run on the sample just before the one that completes a pending change.
    localparam logic [RW-1:0] RunLast = RW'(HOLD - 1);
    localparam logic [RW-1:0] RunOne  = RW'(1);

    state_e        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pop;
    logic          raw;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Population count of the live channel inputs.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + CW'(bus.in[i]);
        end
    end

    // Unsigned compare: thr=0 always votes, thr>N never votes.
    assign raw = (pop >= bus.thr);

    // Persistence FSM next-state, run counter and event pulses.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                StLo: begin
                    if (raw) begin
                        if (HOLD == 1) begin
                            state_d = StHi;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = StPendHi;
                            run_d   = RunOne;
                        end
                    end
                end
                StPendHi: begin
                    if (raw) begin
                        if (run_q == RunLast) begin
                            state_d = StHi;
                            run_d   = '0;
                            rise_d  = 1'b1;
                        end else begin
                            run_d = run_q + RunOne;
                        end
                    end else begin
                        state_d = StLo;
                        run_d   = '0;
                    end
                end
                StHi: begin
                    if (!raw) begin
                        if (HOLD == 1) begin
                            state_d = StLo;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = StPendLo;
                            run_d   = RunOne;
                        end
                    end
                end
                StPendLo: begin
                    if (!raw) begin
                        if (run_q == RunLast) begin
                            state_d = StLo;
                            run_d   = '0;
                            fall_d  = 1'b1;
                        end else begin
                            run_d = run_q + RunOne;
                        end
                    end else begin
                        state_d = StHi;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = StLo;
                    run_d   = '0;
                end
            endcase
        end
    end

    // State, run and pulse registers; pulses self-clear on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLo;
            run_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Count register tracks the popcount of the most recent enabled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.en) begin
            count_q <= pop;
        end
    end

    assign bus.vote_out = (state_q == StHi) || (state_q == StPendLo);
    assign bus.count    = count_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(rise_q && fall_q));

    a_run_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        run_q <= RunLast);

    a_run_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == StLo) || (state_q == StHi)) |-> (run_q == '0));

endmodule

// File: tb/tb_vote_filter.sv
// Directed bench: HOLD=1 and HOLD=3 filters driven with the same samples.
module tb_vote_filter;

    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;

    vote_filter_if #(.N(N)) bus1 ();
    vote_filter_if #(.N(N)) bus3 ();

    vote_filter #(.N(N), .HOLD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    vote_filter #(.N(N), .HOLD(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one sample to both filters, then sample outputs 1 time unit after the edge.
    task automatic tick(input logic e, input logic [3:0] v, input logic [2:0] t);
        bus1.en  = e;
        bus1.in  = v;
        bus1.thr = t;
        bus3.en  = e;
        bus3.in  = v;
        bus3.thr = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string tag, input logic v, input logic r, input logic f);
        check({tag, ".vote"}, 32'(bus3.vote_out), 32'(v));
        check({tag, ".rise"}, 32'(bus3.rise), 32'(r));
        check({tag, ".fall"}, 32'(bus3.fall), 32'(f));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Inputs with at least three ones: 0111, 1011, 1101, 1110, 1111.
    logic [15:0] vote_mask;
    logic [2:0]  pop_tab [16];

    initial begin
        logic prev;
        logic exp;

        vote_mask = 16'hE880;
        pop_tab = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
                    3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4};

        rst_n = 1'b0;
        bus1.en = 1'b0; bus1.in = '0; bus1.thr = '0;
        bus3.en = 1'b0; bus3.in = '0; bus3.thr = '0;
        #12;
        check("rst1.vote", 32'(bus1.vote_out), 0);
        check("rst1.count", 32'(bus1.count), 0);
        check("rst1.rise", 32'(bus1.rise), 0);
        check("rst1.fall", 32'(bus1.fall), 0);
        check3("rst3", 1'b0, 1'b0, 1'b0);
        check("rst3.count", 32'(bus3.count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // HOLD=1 sweep: vote_out is raw delayed by one edge.
        prev = 1'b0;
        for (int v = 0; v < 16; v++) begin
            tick(1'b1, 4'(v), 3'd3);
            exp = vote_mask[v];
            check($sformatf("sweep%0d.vote", v), 32'(bus1.vote_out), 32'(exp));
            check($sformatf("sweep%0d.count", v), 32'(bus1.count), 32'(pop_tab[v]));
            check($sformatf("sweep%0d.rise", v), 32'(bus1.rise), 32'(exp && !prev));
            check($sformatf("sweep%0d.fall", v), 32'(bus1.fall), 32'(!exp && prev));
            prev = exp;
        end

        // HOLD=3: two qualifying samples then a break, no rise.
        do_reset();
        tick(1'b1, 4'hF, 3'd3); check3("pend1", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("pend2", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd3); check3("break", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("up1", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("up2", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("up3", 1'b1, 1'b1, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("hi", 1'b1, 1'b0, 1'b0);

        // From HI: two low samples then a high one, no fall; then three lows.
        tick(1'b1, 4'h0, 3'd3); check3("plo1", 1'b1, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd3); check3("plo2", 1'b1, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("back_hi", 1'b1, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd3); check3("dn1", 1'b1, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd3); check3("dn2", 1'b1, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd3); check3("dn3", 1'b0, 1'b0, 1'b1);
        tick(1'b1, 4'h0, 3'd3); check3("lo", 1'b0, 1'b0, 1'b0);

        // Disabled gap neither breaks nor extends a pending run.
        tick(1'b1, 4'hF, 3'd3); check3("gap_e1", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("gap_e2", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 4'h0, 3'd3);
            check3($sformatf("gap_off%0d", k), 1'b0, 1'b0, 1'b0);
            check($sformatf("gap_off%0d.count", k), 32'(bus3.count), 4);
        end
        tick(1'b1, 4'hF, 3'd3); check3("gap_e7", 1'b1, 1'b1, 1'b0);
        tick(1'b0, 4'h0, 3'd3); check3("gap_clr", 1'b1, 1'b0, 1'b0);

        // thr=0 votes on an all-zero input.
        do_reset();
        tick(1'b1, 4'h0, 3'd0);
        check3("thr0_1", 1'b0, 1'b0, 1'b0);
        check("thr0_1.h1vote", 32'(bus1.vote_out), 1);
        tick(1'b1, 4'h0, 3'd0); check3("thr0_2", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'h0, 3'd0); check3("thr0_3", 1'b1, 1'b1, 1'b0);
        check("thr0_3.count", 32'(bus3.count), 0);

        // thr above N never votes.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 4'hF, 3'd5);
            check3($sformatf("thr5_%0d", k), 1'b0, 1'b0, 1'b0);
            check($sformatf("thr5_%0d.count", k), 32'(bus3.count), 4);
            check($sformatf("thr5_%0d.h1vote", k), 32'(bus1.vote_out), 0);
        end

        // Asynchronous reset mid-cycle during PEND_HI discards the run.
        do_reset();
        tick(1'b1, 4'hF, 3'd3);
        tick(1'b1, 4'hF, 3'd3);
        check("prerst.count", 32'(bus3.count), 4);
        #3;
        rst_n = 1'b0;
        #1;
        check3("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst.count", 32'(bus3.count), 0);
        check("async_rst.h1vote", 32'(bus1.vote_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 4'hF, 3'd3); check3("post1", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("post2", 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 3'd3); check3("post3", 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
